// File: rtl/led_status_pkg.sv
// Shared encodings for the board LED output stage.
package led_status_pkg;

  typedef enum logic [1:0] {
    MODE_HEARTBEAT = 2'd0,
    MODE_STATUS    = 2'd1,
    MODE_BLANK     = 2'd2,
    MODE_LAMP      = 2'd3
  } mode_e;

  typedef enum logic {
    ST_LAMP_TEST = 1'b0,
    ST_RUN       = 1'b1
  } state_e;

  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  localparam logic [7:0] LED_ALL_ON  = 8'h00;

endpackage

// File: rtl/led_status_driver_stretcher.sv
// Holds 'active' high for STRETCH_CYCLES cycles after the last trig pulse.
// A trig while already active reloads the full count.
module pulse_stretcher #(
  parameter int STRETCH_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic active
);

  localparam int CW = $clog2(STRETCH_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(STRETCH_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/led_status_driver.sv
// Active-low LED bank driver: post-reset lamp test, then heartbeat/status/blank
// selected by mode_sel. Output is registered so the pins never glitch.
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int STRETCH_CYCLES = 1048576,
  parameter int BLINK_W        = 24,
  parameter int LAMP_CYCLES    = 16777216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hb_led,
  input  logic [3:0] evt,
  input  logic [3:0] err,
  input  logic       err_clr,
  input  logic [1:0] mode_sel,
  output logic [7:0] led
);

  localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);

  state_e             state, state_nxt;
  logic [LAMP_W-1:0]  lamp_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [3:0]         err_latch;
  logic [3:0]         stretched;
  logic [7:0]         led_nxt;
  logic               blink;
  logic               lamp_done;

  assign blink     = blink_cnt[BLINK_W-1];
  assign lamp_done = (lamp_cnt == LAMP_W'(LAMP_CYCLES - 1));

  for (genvar i = 0; i < 4; i++) begin : g_stretch
    pulse_stretcher #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_stretch (
      .clk   (clk),
      .rst   (rst),
      .trig  (evt[i]),
      .active(stretched[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LAMP_TEST;
      lamp_cnt  <= '0;
      blink_cnt <= '0;
      err_latch <= '0;
      led       <= LED_ALL_OFF;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt + BLINK_W'(1);
      // A new error on the clearing edge survives the clear.
      err_latch <= (err_clr ? 4'h0 : err_latch) | err;
      led       <= led_nxt;
      if (state == ST_LAMP_TEST) begin
        lamp_cnt <= lamp_cnt + LAMP_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = LED_ALL_OFF;
    case (state)
      ST_LAMP_TEST: begin
        led_nxt = LED_ALL_ON;
        if (lamp_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        case (mode_sel)
          MODE_HEARTBEAT: led_nxt = hb_led;
          MODE_STATUS:    led_nxt = {~(err_latch & {4{blink}}), ~stretched};
          MODE_BLANK:     led_nxt = LED_ALL_OFF;
          MODE_LAMP:      led_nxt = LED_ALL_ON;
          default:        led_nxt = LED_ALL_OFF;
        endcase
      end
      default: state_nxt = ST_LAMP_TEST;
    endcase
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed + randomized bench for led_status_driver against an edge-count reference model.
module tb_led_status_driver;

  localparam int N     = 8;
  localparam int BW    = 4;
  localparam int LAMP  = 16;
  localparam int BLINK_HALF = 1 << (BW - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hb_led = 8'hFE;
  logic [3:0] evt = 4'h0;
  logic [3:0] err = 4'h0;
  logic       err_clr = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [7:0] led;

  int total = 0;
  int bad   = 0;

  // Model state: edges seen since reset release, edge index of each channel's
  // last event, and the latched error set.
  int         edges;
  int         last_evt [4];
  logic [3:0] m_latch;

  led_status_driver #(
    .STRETCH_CYCLES(N),
    .BLINK_W       (BW),
    .LAMP_CYCLES   (LAMP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .hb_led  (hb_led),
    .evt     (evt),
    .err     (err),
    .err_clr (err_clr),
    .mode_sel(mode_sel),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    edges   = 0;
    m_latch = 4'h0;
    for (int i = 0; i < 4; i++) last_evt[i] = -1000;
  endtask

  // Expected led after the next edge, from the state after 'edges' edges.
  function automatic logic [7:0] model_led();
    logic [7:0] r;
    logic       bl;
    if (edges + 1 <= LAMP) return 8'h00;
    bl = ((edges % (1 << BW)) >= BLINK_HALF);
    case (mode_sel)
      2'd0: r = hb_led;
      2'd1: begin
        for (int i = 0; i < 4; i++) begin
          r[i]   = !((edges - last_evt[i]) < N);
          r[4+i] = !(m_latch[i] && bl);
        end
      end
      2'd2: r = 8'hFF;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: led=%h expected=%h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic tick(input string tag);
    logic [7:0] exp;
    exp = model_led();
    @(posedge clk);
    edges++;
    for (int i = 0; i < 4; i++) if (evt[i]) last_evt[i] = edges;
    m_latch = (err_clr ? 4'h0 : m_latch) | err;
    #1;
    check(tag, led, exp);
  endtask

  task automatic pulse(input string tag, input logic [3:0] e, input logic [3:0] r, input logic c);
    evt = e; err = r; err_clr = c;
    tick(tag);
    evt = 4'h0; err = 4'h0; err_clr = 1'b0;
  endtask

  task automatic rand_inputs(input bit sparse);
    evt     = 4'($urandom) & (sparse && ($urandom_range(0, 3) != 0) ? 4'h0 : 4'hF);
    err     = 4'($urandom) & (($urandom_range(0, 5) == 0) ? 4'hF : 4'h0);
    err_clr = ($urandom_range(0, 9) == 0);
    hb_led  = 8'($urandom);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", led, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Lamp test then heartbeat passthrough.
    idle("lamp_hb", LAMP + 2);
    for (int i = 0; i < 8; i++) begin
      hb_led = 8'($urandom);
      tick("hb_follow");
    end

    // Stretch, retrigger.
    mode_sel = 2'd1;
    idle("status_idle", 2);
    pulse("evt2", 4'h4, 4'h0, 1'b0);
    idle("stretch", 3);
    pulse("evt2_retrig", 4'h4, 4'h0, 1'b0);
    idle("stretch_tail", N + 3);

    // Error blink, then clear.
    pulse("err1", 4'h0, 4'h2, 1'b0);
    idle("err1_blink", 2 * (1 << BW) + 3);
    pulse("err_clr", 4'h0, 4'h0, 1'b1);
    idle("after_clr", 3);

    // Set wins over simultaneous clear.
    pulse("err3_clr", 4'h0, 4'h8, 1'b1);
    idle("err3_blink", 2 * (1 << BW));

    // Blank and lamp overrides.
    for (int m = 2; m < 4; m++) begin
      mode_sel = 2'(m);
      for (int i = 0; i < 10; i++) begin
        rand_inputs(1'b0);
        tick(m == 2 ? "blank" : "lamp_mode");
      end
    end

    // Randomized status traffic.
    mode_sel = 2'd1;
    for (int i = 0; i < 80; i++) begin
      rand_inputs(1'b1);
      tick("rand_status");
    end
    evt = 4'h0; err = 4'h0; err_clr = 1'b0;

    // Reset in the middle of a stretch with latched errors.
    pulse("pre_rst_err", 4'h1, 4'h5, 1'b0);
    idle("pre_rst", 2);
    #2 rst = 1'b1;
    #1 check("mid_reset_async", led, 8'hFF);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("mid_reset_hold", led, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAMP + 12; i++) begin
      if (i == 4) begin
        evt = 4'h3; err = 4'h4;
      end
      tick("relamp");
      evt = 4'h0; err = 4'h0;
    end

    // Randomized modes across the lot.
    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 0) mode_sel = 2'($urandom);
      rand_inputs(1'b1);
      tick("rand_all");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
